instruction_fetch_unit: RTL and testbench

Sequences the program ROM for the processor core. Holds the program counter, drives the ROM address, captures the combinational ROM output into a small prefetch queue, and presents instructions to decode through a valid/ready handshake. Also handles branch redirects (flush and refetch) and a halt request. Sits between the ROM and the decode/execute stage.

---
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit : PC sequencer, ROM addressing and prefetch queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 16,
  parameter int INSTR_W    = 28
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oRomAddress,
  input  logic [INSTR_W-1:0] iRomInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oInstrPC,
  output logic               oValid,
  input  logic               iReady,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic               iHalt,
  output logic               oHalted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_valid;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_instr_pc;

  logic                w_pop;
  logic                w_push;
  logic [PTR_W-1:0]    w_rd_ptr_nxt;
  logic [PTR_W-1:0]    w_wr_ptr_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [INSTR_W-1:0]  w_head_data;
  logic [ADDR_W-1:0]   w_head_addr;

  always_comb begin
    w_pop        = r_valid & iReady;
    w_push       = (r_state == ST_RUN) & ~iBranchTaken & ((r_count < C_DEPTH) | w_pop);
    w_rd_ptr_nxt = '0;
    w_wr_ptr_nxt = '0;
    w_count_nxt  = '0;
    if (!iBranchTaken) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // The next head is the word being pushed this cycle when it lands in the
  // slot the read pointer is about to point at (queue empty or draining to empty).
  always_comb begin
    w_head_data = r_data[w_rd_ptr_nxt];
    w_head_addr = r_addr[w_rd_ptr_nxt];
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_data = iRomInstruction;
      w_head_addr = r_pc;
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= iRomInstruction;
      r_addr[r_wr_ptr] <= r_pc;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= ST_RUN;
      r_pc       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      if (iBranchTaken) begin
        r_pc <= iBranchTarget;
      end else if (w_push) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_instr    <= w_head_data;
        r_instr_pc <= w_head_addr;
      end else begin
        r_instr    <= '0;
        r_instr_pc <= '0;
      end
      r_state <= iHalt ? ST_HALT : ST_RUN;
    end
  end

  assign oRomAddress  = r_pc;
  assign oValid       = r_valid;
  assign oInstruction = r_instr;
  assign oInstrPC     = r_instr_pc;
  assign oHalted      = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// tb_instruction_fetch_unit : directed + randomized checks against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic [27:0] rom_data;
  logic [27:0] instr;
  logic [15:0] ipc;
  logic        valid;
  logic        ready;
  logic        br;
  logic [15:0] target;
  logic        halt;
  logic        halted;

  always #5 clk = ~clk;

  assign rom_data = 28'h100 + {12'h0, rom_addr};

  instruction_fetch_unit #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (16),
    .INSTR_W   (28)
  ) dut (
    .Clock          (clk),
    .Reset          (rst_n),
    .oRomAddress    (rom_addr),
    .iRomInstruction(rom_data),
    .oInstruction   (instr),
    .oInstrPC       (ipc),
    .oValid         (valid),
    .iReady         (ready),
    .iBranchTaken   (br),
    .iBranchTarget  (target),
    .iHalt          (halt),
    .oHalted        (halted)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of {instruction, pc} plus PC and halt flag
  typedef struct packed {
    logic [27:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        q[$];
  ent_t        m_ent;
  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_pop;
  bit          m_push;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      q.delete();
      m_pc     = 16'h0;
      m_halted = 1'b0;
      started  = 1'b1;
    end else if (started) begin
      m_pop  = (q.size() > 0) && ready;
      m_push = !m_halted && !br && ((q.size() < DEPTH) || m_pop);
      if (br) begin
        q.delete();
        m_pc = target;
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
          m_ent.instr = 28'h100 + {12'h0, m_pc};
          m_ent.pc    = m_pc;
          q.push_back(m_ent);
          m_pc = m_pc + 16'h1;
        end
      end
      m_halted = halt;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("oValid", valid, q.size() > 0);
      check("oInstruction", instr, (q.size() > 0) ? q[0].instr : 28'h0);
      check("oInstrPC", ipc, (q.size() > 0) ? q[0].pc : 16'h0);
      check("oRomAddress", rom_addr, m_pc);
      check("oHalted", halted, m_halted);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, valid, 1'b0);
    check({tag, ".instr"}, instr, 28'h0);
    check({tag, ".ipc"}, ipc, 16'h0);
    check({tag, ".romaddr"}, rom_addr, 16'h0);
    check({tag, ".halted"}, halted, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ready  = 1'b1;
    br     = 1'b0;
    target = 16'h0;
    halt   = 1'b0;

    // Reset and streaming
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stream.valid", valid, 1'b1);
      check("stream.pc", ipc, 16'(i));
      check("stream.instr", instr, 28'h100 + 28'(i));
    end

    // Backpressure from reset release
    rst_n = 1'b0;
    ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("bp.romaddr", rom_addr, 16'h2);
    check("bp.pc0", ipc, 16'h0);
    ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("bp.valid", valid, 1'b1);
      check("bp.pc", ipc, 16'(i));
    end
    check("bp.full_romaddr", rom_addr, 16'h5);

    // Branch with full queue while head is PC 3
    br     = 1'b1;
    target = 16'h0040;
    tick();
    br = 1'b0;
    check("br.valid", valid, 1'b0);
    check("br.romaddr", rom_addr, 16'h0040);
    tick();
    check("br.pc", ipc, 16'h0040);
    check("br.instr", instr, 28'h140);
    tick();
    check("br.pc_next", ipc, 16'h0041);

    // Wrap-around
    br     = 1'b1;
    target = 16'hFFFE;
    tick();
    br = 1'b0;
    tick();
    check("wrap.pc0", ipc, 16'hFFFE);
    tick();
    check("wrap.pc1", ipc, 16'hFFFF);
    tick();
    check("wrap.pc2", ipc, 16'h0000);
    tick();
    check("wrap.pc3", ipc, 16'h0001);

    // Halt with one entry queued
    halt = 1'b1;
    tick();
    check("halt.halted", halted, 1'b1);
    check("halt.pc", ipc, 16'h0002);
    check("halt.romaddr", rom_addr, 16'h0003);
    tick();
    check("halt.drained", valid, 1'b0);
    check("halt.romaddr_hold", rom_addr, 16'h0003);
    halt = 1'b0;
    tick();
    check("resume.halted", halted, 1'b0);
    check("resume.valid", valid, 1'b0);
    tick();
    check("resume.pc", ipc, 16'h0003);

    // Reset with full queue and branch pending
    ready = 1'b0;
    tick();
    tick();
    br     = 1'b1;
    target = 16'h0099;
    rst_n  = 1'b0;
    tick();
    check_reset_outputs("midreset");
    br    = 1'b0;
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    check("restart.pc", ipc, 16'h0000);
    check("restart.instr", instr, 28'h100);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      br    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) target = 16'hFFFC + 16'($urandom_range(0, 3));
      else                           target = 16'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      tick();
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
